// File: rtl/ks_nibble_serial_adder.sv
// rtl/ks_nibble_serial_adder.sv - WIDTH-bit adder time-multiplexing an external 4-bit Kogge-Stone adder
// Processes one nibble per cycle, least-significant nibble first, with valid/ready on both sides.
module ks_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int NIB = WIDTH / 4;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CW-1:0]    nib_cnt;
  logic             running;

  assign running   = (state == RUN);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_reg;
  assign cout_out  = cout_reg;
  assign ovf_out   = ovf_reg;

  // The external adder is combinational, so its operands are driven straight from the registers.
  assign add_a   = running ? a_reg[4*nib_cnt +: 4] : 4'd0;
  assign add_b   = running ? b_reg[4*nib_cnt +: 4] : 4'd0;
  assign add_cin = running ? carry_reg : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nib_cnt    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= cin_in;
            nib_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result_reg[4*nib_cnt +: 4] <= add_sum;
          carry_reg                  <= add_cout;
          if (nib_cnt == LAST) begin
            // The top nibble is being written this edge, so take the sign from add_sum directly.
            state    <= DONE;
            cout_reg <= add_cout;
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[3] != a_reg[WIDTH-1]);
          end else begin
            nib_cnt <= nib_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_nibble_serial_adder.sv
// tb/tb_ks_nibble_serial_adder.sv - self-checking bench for ks_nibble_serial_adder
// Table vectors, hand-written corner sequences and random operands against an arithmetic model.
module tb_ks_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout_out;
  logic             ovf_out;

  ks_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout_out(cout_out), .ovf_out(ovf_out)
  );

  // Stand-in for the external 4-bit Kogge-Stone adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic cin_seen [NIB];
  int cyc = 0;
  int accept_q[$];
  logic [WIDTH:0] res_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) accept_q.push_back(cyc);
    if (!rst && out_valid && out_ready) res_q.push_back({cout_out, result});
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b, input logic c, input int i);
    longint unsigned mask;
    mask = (64'd1 << (4 * i)) - 1;
    return ((((longint'(a) & mask) + (longint'(b) & mask) + longint'(c)) >> (4 * i)) & 1) != 0;
  endfunction

  // Drives one operand set, returns at the first negedge with out_valid high.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    op_a = a; op_b = b; cin_in = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (lat < NIB) cin_seen[lat] = add_cin;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NIB);
  endtask

  task automatic check_result(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] s;
    logic ovf;
    s = {1'b0, a} + {1'b0, b} + {16'd0, c};
    ovf = (a[15] == b[15]) && (s[15] != a[15]);
    check("result", result, s[15:0]);
    check("cout_out", cout_out, s[16]);
    check("ovf_out", ovf_out, ovf);
    for (int i = 0; i < NIB; i++) check("add_cin_nibble", cin_seen[i], carry_into(a, b, c, i));
  endtask

  task automatic release_ok();
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_pop", out_valid, 0);
    check("in_ready_after_pop", in_ready, 1);
  endtask

  vec_t tbl [4];
  logic [15:0] ra, rb, held;
  logic rc;
  int stall, n;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);

    for (int i = 0; i < 4; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].c);
      check("tbl_result", result, tbl[i].res);
      check("tbl_cout", cout_out, tbl[i].cout);
      check("tbl_ovf", ovf_out, tbl[i].ovf);
      check_result(tbl[i].a, tbl[i].b, tbl[i].c);
      release_ok();
      check("idle_add_a", add_a, 0);
    end

    // Backpressure holds DONE with stable outputs.
    out_ready = 1'b0;
    start_op(16'hDB00, 16'h0B00, 1'b0);
    check("bp_result", result, 16'hE600);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result_stable", result, 16'hE600);
      check("bp_in_ready", in_ready, 0);
    end
    release_ok();

    // Reset after two nibbles aborts the addition.
    op_a = 16'hABCD; op_b = 16'h1234; cin_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_out_valid", out_valid, 0);
    check("rst_run_result", result, 0);
    check("rst_run_in_ready", in_ready, 1);
    check("rst_run_add_cin", add_cin, 0);
    start_op(16'h0000, 16'h0000, 1'b1);
    check("post_rst_result", result, 16'h0001);
    check("post_rst_cout", cout_out, 0);
    release_ok();

    // Back-to-back with in_valid held high.
    accept_q.delete();
    res_q.delete();
    op_a = 16'h0F0F; op_b = 16'hF0F0; cin_in = 1'b0; in_valid = 1'b1;
    n = 0;
    while (accept_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
    op_a = 16'hFFFF; op_b = 16'hFFFF; cin_in = 1'b1;
    while (accept_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    while (res_q.size() < 2 && n < 150) begin @(negedge clk); n++; end
    check("b2b_accepts", accept_q.size(), 2);
    check("b2b_results", res_q.size(), 2);
    if (accept_q.size() == 2) check("b2b_spacing", accept_q[1] - accept_q[0], NIB + 2);
    if (res_q.size() == 2) begin
      check("b2b_res0", res_q[0], {1'b0, 16'hFFFF});
      check("b2b_res1", res_q[1], {1'b1, 16'hFFFF});
    end
    @(negedge clk);

    // Random operands with random backpressure.
    for (int k = 0; k < 30; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      stall = $urandom_range(0, 2);
      out_ready = (stall == 0);
      start_op(ra, rb, rc);
      held = result;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("rnd_hold", result, held);
      end
      check_result(ra, rb, rc);
      if (stall == 0) begin
        @(negedge clk);
        check("rnd_pop", out_valid, 0);
      end else begin
        release_ok();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ks_nibble_serial_adder.md
Name: ks_nibble_serial_adder

Overview:
- Sequential wrapper that performs WIDTH-bit additions by time-multiplexing one external 4-bit KoggeStone adder, one nibble per cycle, least-significant nibble first.
- Sits directly upstream and downstream of the KoggeStone instance. It drives the adder's A/B/Cin and consumes its Sum/Cout.
- Offers valid/ready handshakes on the operand and result sides to the surrounding datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- cin_in  in  1  carry-in for the whole addition
- add_a  out  4  nibble of A to KoggeStone A
- add_b  out  4  nibble of B to KoggeStone B
- add_cin  out  1  carry to KoggeStone Cin
- add_sum  in  4  KoggeStone Sum (combinational, same cycle)
- add_cout  in  1  KoggeStone Cout
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum
- cout_out  out  1  final carry-out
- ovf_out  out  1  signed overflow

Behaviour:
- One clock; reset is synchronous and active-high.
- State machine has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register op_a, op_b and cin_in into a_reg, b_reg and carry_reg. Clear nib_cnt to 0 and go to RUN.
  - RUN: in_ready=0. Drive add_a=a_reg[4*nib_cnt+:4], add_b=b_reg[4*nib_cnt+:4], add_cin=carry_reg.
    - Each edge: result_reg[4*nib_cnt+:4]<=add_sum, carry_reg<=add_cout, nib_cnt++.
    - At the edge where nib_cnt==NIB-1, go to DONE instead of incrementing.
  - DONE: out_valid=1. result, cout_out and ovf_out are held stable. On out_valid&&out_ready go to IDLE.
- Outputs in IDLE and RUN:
  - add_a and add_b are 0 outside RUN.
  - add_cin is 0 outside RUN.
- Result fields:
  - cout_out=carry_reg after the last nibble.
  - ovf_out=(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (result_reg[WIDTH-1]!=a_reg[WIDTH-1]), registered at the DONE transition.
  - Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout_out.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (NIB=4 gives 4 cycles).
  - Throughput is one addition per NIB+2 cycles when out_ready is held high.
- No pipelining: in_valid during RUN or DONE is ignored (in_ready=0). Operands must be held by the producer until accepted.
- Backpressure: the block stays in DONE indefinitely while out_ready=0, with outputs unchanged.
- Reset value of all outputs:
  - in_ready=1 once state is IDLE after reset.
  - out_valid=0.
  - result=0, cout_out=0, ovf_out=0.
  - add_a=0, add_b=0, add_cin=0.
- Reset value of internal state: state=IDLE, nib_cnt=0, carry_reg=0.
- Reset mid-operation: reset during RUN or DONE aborts the addition with no output handshake and returns to IDLE on the next edge with the reset values above.
- Simultaneous events:
  - rst overrides every handshake in the same cycle.
  - out handshake in DONE plus in_valid in the same cycle: the block returns to IDLE first. The new operands are accepted on the following cycle.
- WIDTH=4 boundary: RUN lasts one cycle, then DONE.

Test Plan (WIDTH=16, KoggeStone instance connected, out_ready=1 unless stated):
- op_a=0x1234, op_b=0x4321, cin_in=1 -> 4 cycles after accept: result=0x5556, cout_out=0, ovf_out=0, out_valid for 1 cycle.
- op_a=0xFFFF, op_b=0x0001, cin_in=0 -> result=0x0000, cout_out=1, ovf_out=0. The carry ripples through all 4 nibbles; check add_cin=1 on nibbles 1-3.
- op_a=0x7FFF, op_b=0x0001, cin_in=0 -> result=0x8000, cout_out=0, ovf_out=1. Then op_a=0x8000, op_b=0x8000 -> result=0x0000, cout_out=1, ovf_out=1.
- Backpressure: op_a=0xDB00, op_b=0x0B00, out_ready=0 for 3 cycles -> out_valid held high with result=0xE600 stable, in_ready=0. Assert out_ready -> IDLE the next cycle, in_ready=1.
- Reset during RUN (after 2 nibbles) -> the next cycle is IDLE with out_valid=0, result=0, in_ready=1. A following 0x0000+0x0000 with cin_in=1 gives result=0x0001, cout_out=0.
- Back-to-back: in_valid held high with two operand sets (0x0F0F+0xF0F0, then 0xFFFF+0xFFFF with cin_in=1) -> results 0xFFFF/cout 0, then 0xFFFF/cout 1. The second accept occurs exactly NIB+2 cycles after the first.
